assoc_cache_ctrl: RTL
=====================

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter OFFSET_W, default 2, block-offset bits (address LSBs, ignored for lookup).
REQ-003 SHALL have parameter INDEX_W, default 4, set-index bits; sets = 2^INDEX_W.
REQ-004 SHALL have parameter WAYS, default 2, associativity; legal 1, 2, 4.
REQ-005 SHALL have parameter FILL_LAT, default 4, miss-fill cycles; legal 1..255.
REQ-006 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-007 SHALL use one clock and a synchronous, active-low reset.
REQ-008 SHALL have these ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  lookup request present.
req_ready  out  1  block accepts request this cycle.
req_addr  in  ADDR_W  request address; tag = bits above offset+index.
flush  in  1  invalidate all lines.
resp_valid  out  1  one-cycle pulse, lookup result.
resp_hit  out  1  1 = hit, 0 = miss; valid with resp_valid.
resp_way  out  max(1,log2 WAYS)  way hit or filled; valid with resp_valid.
hit_count  out  CNT_W  total hits since reset.
miss_count  out  CNT_W  total misses since reset.

Function
REQ-009 SHALL decode index = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag = req_addr[ADDR_W-1:OFFSET_W+INDEX_W].
REQ-010 SHALL store per set per way: valid bit, tag, LRU age (0 = most recent, WAYS-1 = least recent).
REQ-011 SHALL implement states IDLE and FILL; req_ready = (state==IDLE) && !flush && !flush_pending.
REQ-012 SHALL accept a request on a cycle with req_valid && req_ready; addr captured at that edge.
REQ-013 Hit (valid && tag match in any way): resp_valid=1, resp_hit=1, resp_way=matching way on the cycle after accept; state stays IDLE; back-to-back hits sustain one per cycle.
REQ-014 Miss: enter FILL for exactly FILL_LAT cycles with req_ready=0; on the final FILL edge install tag into victim way (valid=1), pulse resp_valid with resp_hit=0 and resp_way=victim, return to IDLE; accept-to-resp latency FILL_LAT+1 cycles.
REQ-015 Victim SHALL be the lowest-numbered invalid way of the set; if all valid, the way with age WAYS-1.
REQ-016 On hit or install, accessed way age becomes 0; every other way in the set with age below accessed way's old age increments; ages remain a permutation of 0..WAYS-1.
REQ-017 WAYS=1 SHALL behave as direct-mapped; resp_way tied 0.
REQ-018 hit_count/miss_count SHALL increment on the resp_valid cycle per resp_hit and saturate at all-ones.
REQ-019 flush in IDLE SHALL clear all valid bits at that edge (ages reset per REQ-021), no request accepted that cycle; counters unchanged.
REQ-020 flush during FILL SHALL be latched as flush_pending, ignored by the in-flight fill, applied on the first IDLE cycle (after the install), then cleared.

Reset
REQ-021 While rst_n=0 at an edge: state=IDLE, all valid=0, age of way w = w in every set, counters=0, resp_valid=0, resp_hit=0, resp_way=0, flush_pending=0; req_ready=1 on the first cycle after release.
REQ-022 Reset mid-FILL SHALL abort the fill with no install and no resp_valid.

Verification (INDEX_W=4, OFFSET_W=2, WAYS=2, FILL_LAT=4 unless stated)
REQ-023 Cold miss then hit: 0x40 -> req_ready low 4 cycles, resp at accept+5 hit=0 way=0; 0x40 again -> resp at accept+1 hit=1 way=0; counts 1/1.
REQ-024 LRU: A=0x000, B=0x040, C=0x080 (all set 0) sequence A,B,A,C,A -> M,M,H,M(way1, evicts B),H; hit_count=2, miss_count=3.
REQ-025 WAYS=1: A,B,A -> three misses, resp_way=0 throughout.
REQ-026 Flush: install A, flush in IDLE, A -> miss; counters not cleared; flush asserted during a FILL -> fill completes, next A lookup misses.
REQ-027 rst_n low on 2nd FILL cycle -> no resp_valid, counters 0, req_ready=1 one cycle after release, prior line misses.
REQ-028 CNT_W=4: 1 miss then 16 hits on same address -> hit_count holds 15, miss_count=1.

Source files
------------

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: set-associative tag-lookup controller with LRU replacement,
// fixed-latency miss fill, deferred flush and saturating hit/miss statistics.
module assoc_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 2,
  parameter int FILL_LAT = 4,
  parameter int CNT_W    = 32,
  localparam int WW      = WAYS > 1 ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WW-1:0]     resp_way,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;
  logic [WAYS-1:0]    valid [SETS];
  logic [TAG_W-1:0]   tags  [SETS][WAYS];
  logic [WW-1:0]      ages  [SETS][WAYS];
  logic [INDEX_W-1:0] idx, fill_idx, acc_idx;
  logic [TAG_W-1:0]   tg, fill_tag;
  logic [7:0]         fcnt;
  logic               flush_pending, accept, install, do_flush, hit;
  logic [WW-1:0]      hit_way, victim, acc_way, old_age;
  logic               unused_offset;
  assign idx = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tg  = req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];
  // Descending scans let the lowest-numbered match / invalid way win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[idx][w] && tags[idx][w] == tg) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (ages[fill_idx][w] == WW'(WAYS - 1)) victim = WW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[fill_idx][w]) victim = WW'(w);
  end
  always_comb begin
    req_ready = state == IDLE && !flush && !flush_pending;
    accept    = req_valid && req_ready;
    install   = state == FILL && fcnt == 8'(FILL_LAT - 1);
    do_flush  = state == IDLE && (flush || flush_pending);
    state_nxt = install ? IDLE : (accept && !hit) ? FILL : state;
    acc_idx   = install ? fill_idx : idx;
    acc_way   = install ? victim : hit_way;
    old_age   = ages[acc_idx][acc_way];
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      flush_pending <= 1'b0;
      fcnt          <= '0;
      fill_idx      <= '0;
      fill_tag      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) ages[s][w] <= WW'(w);
      end
    end else begin
      resp_valid <= (accept && hit) || install;
      resp_hit   <= accept && hit;
      resp_way   <= acc_way;
      fcnt       <= state == FILL ? fcnt + 8'd1 : 8'd0;
      if (accept) begin
        fill_idx <= idx;
        fill_tag <= tg;
      end
      if (state == FILL && flush) flush_pending <= 1'b1;
      else if (do_flush) flush_pending <= 1'b0;
      if (accept && hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      if (install && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      if (do_flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          for (int w = 0; w < WAYS; w++) ages[s][w] <= WW'(w);
        end
      end else if ((accept && hit) || install) begin
        if (install) begin
          valid[fill_idx][victim] <= 1'b1;
          tags[fill_idx][victim]  <= fill_tag;
        end
        // Only ways more recent than the accessed one age; older ones keep their rank.
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == acc_way) ages[acc_idx][w] <= '0;
          else if (ages[acc_idx][w] < old_age) ages[acc_idx][w] <= ages[acc_idx][w] + WW'(1);
      end
    end
  end
endmodule
